rf_writeback_ctrl: RTL

Writer-side controller for the 16x16 triple-ported register file. It merges results from the ALU and the memory/load path into a small in-order queue and drains that queue through the register file's single write port (`dst_addr`/`dst`/`we`), one write per cycle. It tells decode which registers still have an uncommitted write, so decode can stall. On halt it drains the queue and then raises `hlt`, so the register dump shows final state.

---
 rtl/rf_writeback_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/rf_writeback_ctrl.sv
// Writeback controller: merges ALU and load results into an in-order queue and
// drains it through the register file's single write port, one write per cycle.
module rf_writeback_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_alu_vld,
    input  logic [3:0]  i_alu_addr,
    input  logic [15:0] i_alu_data,
    output logic        o_alu_rdy,
    input  logic        i_mem_vld,
    input  logic [3:0]  i_mem_addr,
    input  logic [15:0] i_mem_data,
    output logic        o_mem_rdy,
    input  logic [3:0]  i_chk_addr0,
    input  logic [3:0]  i_chk_addr1,
    output logic        o_pend0,
    output logic        o_pend1,
    input  logic        i_hlt_req,
    output logic [3:0]  o_dst_addr,
    output logic [15:0] o_dst,
    output logic        o_we,
    output logic        o_hlt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT} state_t;

    state_t        r_state;
    logic [3:0]    r_addr [DEPTH];
    logic [15:0]   r_data [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [3:0]    r_dst_addr;
    logic [15:0]   r_dst;
    logic          r_we;
    logic          r_hlt;

    logic [CW-1:0]    w_free;
    logic             w_run;
    logic             w_mem_push;
    logic             w_alu_push;
    logic             w_pop;
    logic [AW-1:0]    w_alu_ptr;
    logic [DEPTH-1:0] w_occ;
    logic             w_hit0;
    logic             w_hit1;

    // Ready is based on registered occupancy only; a pop in the same cycle is not credited.
    assign w_free     = CW'(DEPTH) - r_count;
    assign w_run      = (r_state == S_RUN);
    assign o_alu_rdy  = w_run && (w_free >= CW'(2));
    assign o_mem_rdy  = w_run && (w_free != '0);

    assign w_mem_push = i_mem_vld && o_mem_rdy && (i_mem_addr != 4'd0);
    assign w_alu_push = i_alu_vld && o_alu_rdy && (i_alu_addr != 4'd0);
    assign w_pop      = (r_count != '0);
    assign w_alu_ptr  = r_wptr + AW'(w_mem_push);

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ[i] = ({1'b0, AW'(i) - r_rptr} < r_count);
        end
    end

    always_comb begin
        w_hit0 = r_we && (r_dst_addr == i_chk_addr0);
        w_hit1 = r_we && (r_dst_addr == i_chk_addr1);
        for (int i = 0; i < DEPTH; i++) begin
            if (w_occ[i] && (r_addr[i] == i_chk_addr0)) w_hit0 = 1'b1;
            if (w_occ[i] && (r_addr[i] == i_chk_addr1)) w_hit1 = 1'b1;
        end
    end

    assign o_pend0 = (i_chk_addr0 != 4'd0) && w_hit0;
    assign o_pend1 = (i_chk_addr1 != 4'd0) && w_hit1;

    // Storage needs no reset: occupancy is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_mem_push) begin
            r_addr[r_wptr] <= i_mem_addr;
            r_data[r_wptr] <= i_mem_data;
        end
        if (w_alu_push) begin
            r_addr[w_alu_ptr] <= i_alu_addr;
            r_data[w_alu_ptr] <= i_alu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_RUN;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_dst_addr <= '0;
            r_dst      <= '0;
            r_we       <= 1'b0;
            r_hlt      <= 1'b0;
        end else begin
            r_wptr  <= r_wptr + AW'(w_mem_push) + AW'(w_alu_push);
            r_count <= r_count + CW'(w_mem_push) + CW'(w_alu_push) - CW'(w_pop);
            r_we    <= w_pop;
            if (w_pop) begin
                r_dst_addr <= r_addr[r_rptr];
                r_dst      <= r_data[r_rptr];
                r_rptr     <= r_rptr + AW'(1);
            end
            case (r_state)
                S_RUN: begin
                    if (i_hlt_req) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    // Wait for the last presented write to retire before signalling.
                    if ((r_count == '0) && !r_we) begin
                        r_state <= S_HALT;
                        r_hlt   <= 1'b1;
                    end
                end
                S_HALT: begin
                    r_hlt <= 1'b1;
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    assign o_dst_addr = r_dst_addr;
    assign o_dst      = r_dst;
    assign o_we       = r_we;
    assign o_hlt      = r_hlt;

endmodule
